matrix_ls_responder: RTL and testbench

Responder end of the matrix load/store request channel. Accepts one matrix load or store request at a time (ls bits, destination/source matrix register, stride, base address) and walks MAT_DIM rows at base + i*stride. Each row moves between data memory and the matrix register file. A one-cycle mhit pulse back to the issuing functional unit marks completion. Sits between the matrix LS functional unit, the matrix register file and the data-memory port.

---
 rtl/matrix_ls_responder_if.sv | 37 +++
 rtl/matrix_ls_responder.sv | 218 +++++++++++++++++++++
 tb/tb_matrix_ls_responder.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/matrix_ls_responder_if.sv
// ---------------------------------------------------------------------------
// matrix_ls_responder_if
//
// Matrix load/store request channel between the issuing matrix LS functional
// unit (master) and matrix_ls_responder (slave).
//
// Signals:
//   req_ls      master->slave  bit0 = load, bit1 = store (00 idle, 11 illegal)
//   req_rd      master->slave  matrix register index
//   req_stride  master->slave  byte stride between rows
//   req_address master->slave  base byte address
//   req_ready   slave->master  responder is idle and will accept a request
//   mhit        slave->master  one-cycle completion pulse
//   err         slave->master  one-cycle misalignment pulse (with mhit)
// ---------------------------------------------------------------------------
interface matrix_ls_responder_if #(
    parameter int ADDR_W = 32,
    parameter int MREG_W = 4
);
    logic [1:0]        req_ls;
    logic [MREG_W-1:0] req_rd;
    logic [ADDR_W-1:0] req_stride;
    logic [ADDR_W-1:0] req_address;
    logic              req_ready;
    logic              mhit;
    logic              err;

    modport master (
        output req_ls, req_rd, req_stride, req_address,
        input  req_ready, mhit, err
    );

    modport slave (
        input  req_ls, req_rd, req_stride, req_address,
        output req_ready, mhit, err
    );
endinterface

// File: rtl/matrix_ls_responder.sv
// ---------------------------------------------------------------------------
// matrix_ls_responder
//
// Responder end of the matrix load/store channel. Accepts one request at a
// time and walks MAT_DIM rows at base + i*stride (modulo 2^ADDR_W), moving
// each row between data memory and the matrix register file. Completion is
// signalled by a one-cycle mhit pulse.
//
// Ports:
//   CLK, RST        clock, synchronous active-high reset
//   req             request channel (slave modport of matrix_ls_responder_if)
//   mem_ren/wen     memory read / write request (never both high)
//   mem_addr        memory byte address
//   mem_wdata       store data, held with mem_addr until mem_ready
//   mem_rdata       load data, valid when mem_ready
//   mem_ready       current memory access completes this cycle
//   mrf_wen/ren     matrix RF row write / read enable (never both high)
//   mrf_idx/row     matrix register index / row index
//   mrf_wdata       RF row write data
//   mrf_rdata       RF row read data, valid the cycle after mrf_ren
//
// Build option:
//   MLS_ALIGN_CHECK_EN  when defined, a base or stride that is not a multiple
//                       of ROW_W/8 bytes skips all accesses and completes
//                       with mhit and err together. When undefined err is 0
//                       and addresses are issued as given.
// ---------------------------------------------------------------------------
module matrix_ls_responder #(
    parameter int MAT_DIM = 4,
    parameter int ROW_W   = 64,
    parameter int ADDR_W  = 32,
    parameter int MREG_W  = 4
) (
    input  logic                       CLK,
    input  logic                       RST,
    matrix_ls_responder_if.slave       req,
    output logic                       mem_ren,
    output logic                       mem_wen,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [ROW_W-1:0]           mem_wdata,
    input  logic [ROW_W-1:0]           mem_rdata,
    input  logic                       mem_ready,
    output logic                       mrf_wen,
    output logic                       mrf_ren,
    output logic [MREG_W-1:0]          mrf_idx,
    output logic [$clog2(MAT_DIM)-1:0] mrf_row,
    output logic [ROW_W-1:0]           mrf_wdata,
    input  logic [ROW_W-1:0]           mrf_rdata
);
    localparam int                ROW_IW   = $clog2(MAT_DIM);
    localparam logic [ROW_IW-1:0] LAST_ROW = ROW_IW'(MAT_DIM - 1);

    typedef enum logic [2:0] {
        IDLE,
        LD,
        ST_RD,
        ST_WR,
        DONE
    } state_e;

    state_e              state_q, state_d;
    logic [ROW_IW-1:0]   row_q, row_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0]   stride_q, stride_d;
    logic [MREG_W-1:0]   idx_q, idx_d;
    logic [ROW_W-1:0]    buf_q, buf_d;
    // High during the first ST_WR cycle, when mrf_rdata is still on the bus
    // and has not yet been captured into buf_q.
    logic                wr_first_q, wr_first_d;

    logic is_load_req;
    logic is_store_req;
    logic last_row;

    assign is_load_req  = (req.req_ls == 2'b01);
    assign is_store_req = (req.req_ls == 2'b10);
    assign last_row     = (row_q == LAST_ROW);

`ifdef MLS_ALIGN_CHECK_EN
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(ROW_W / 8 - 1);

    logic err_q, err_d;
    logic misaligned;

    assign misaligned = |((req.req_address | req.req_stride) & ALIGN_MASK);
`endif

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values computed by the combinational block.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            row_q      <= '0;
            addr_q     <= '0;
            stride_q   <= '0;
            idx_q      <= '0;
            // NOTE: buf_q is a single row register rather than a storage
            // array, so clearing it on reset is part of the defined reset state.
            buf_q      <= '0;
            wr_first_q <= 1'b0;
`ifdef MLS_ALIGN_CHECK_EN
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            addr_q     <= addr_d;
            stride_q   <= stride_d;
            idx_q      <= idx_d;
            buf_q      <= buf_d;
            wr_first_q <= wr_first_d;
`ifdef MLS_ALIGN_CHECK_EN
            err_q      <= err_d;
`endif
        end
    end

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case statement can leave one unassigned (no latches).
        state_d       = state_q;
        row_d         = row_q;
        addr_d        = addr_q;
        stride_d      = stride_q;
        idx_d         = idx_q;
        buf_d         = buf_q;
        wr_first_d    = wr_first_q;
`ifdef MLS_ALIGN_CHECK_EN
        err_d         = err_q;
`endif
        req.req_ready = 1'b0;
        req.mhit      = 1'b0;
        req.err       = 1'b0;
        mem_ren       = 1'b0;
        mem_wen       = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        mrf_wen       = 1'b0;
        mrf_ren       = 1'b0;
        mrf_idx       = '0;
        mrf_row       = '0;
        mrf_wdata     = '0;

        case (state_q)
            IDLE: begin
                req.req_ready = 1'b1;
                if (is_load_req || is_store_req) begin
                    idx_d    = req.req_rd;
                    stride_d = req.req_stride;
                    addr_d   = req.req_address;
                    row_d    = '0;
                    state_d  = is_load_req ? LD : ST_RD;
`ifdef MLS_ALIGN_CHECK_EN
                    err_d = misaligned;
                    if (misaligned) begin
                        state_d = DONE;
                    end
`endif
                end
            end

            LD: begin
                mem_ren  = 1'b1;
                mem_addr = addr_q;
                mrf_idx  = idx_q;
                mrf_row  = row_q;
                if (mem_ready) begin
                    mrf_wen   = 1'b1;
                    mrf_wdata = mem_rdata;
                    addr_d    = addr_q + stride_q;
                    row_d     = row_q + 1'b1;
                    if (last_row) begin
                        state_d = DONE;
                    end
                end
            end

            ST_RD: begin
                mrf_ren    = 1'b1;
                mrf_idx    = idx_q;
                mrf_row    = row_q;
                wr_first_d = 1'b1;
                state_d    = ST_WR;
            end

            ST_WR: begin
                mem_wen  = 1'b1;
                mem_addr = addr_q;
                // Forward the RF read on the first cycle so an unstalled
                // store costs only two cycles per row; later stall cycles
                // replay the captured copy so mem_wdata stays stable.
                mem_wdata = wr_first_q ? mrf_rdata : buf_q;
                if (wr_first_q) begin
                    buf_d      = mrf_rdata;
                    wr_first_d = 1'b0;
                end
                if (mem_ready) begin
                    addr_d  = addr_q + stride_q;
                    row_d   = row_q + 1'b1;
                    state_d = last_row ? DONE : ST_RD;
                end
            end

            DONE: begin
                req.mhit = 1'b1;
`ifdef MLS_ALIGN_CHECK_EN
                req.err  = err_q;
                err_d    = 1'b0;
`endif
                state_d  = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_matrix_ls_responder.sv
// ---------------------------------------------------------------------------
// tb_matrix_ls_responder
//
// Directed bench for matrix_ls_responder. Stimulus pushes the expected event
// stream (load beats, RF reads, store beats, completion) into a queue; a
// monitor on the falling clock edge pops and compares each event the DUT
// presents, plus per-cycle strobe invariants and store-stall hold checks.
// ---------------------------------------------------------------------------
module tb_matrix_ls_responder;
    localparam int MAT_DIM = 4;
    localparam int ROW_W   = 64;
    localparam int ADDR_W  = 32;
    localparam int MREG_W  = 4;

    typedef enum logic [1:0] {EV_LD, EV_SRD, EV_SWR, EV_HIT} ev_kind_e;

    typedef struct {
        ev_kind_e          kind;
        logic [ADDR_W-1:0] addr;
        logic [ROW_W-1:0]  data;
        logic [MREG_W-1:0] idx;
        logic [1:0]        row;
        logic              err;
        int                cyc;   // -1 = cycle not checked
    } ev_t;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    matrix_ls_responder_if #(.ADDR_W(ADDR_W), .MREG_W(MREG_W)) rif ();

    logic              mem_ren, mem_wen, mem_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [ROW_W-1:0]  mem_wdata, mem_rdata;
    logic              mrf_wen, mrf_ren;
    logic [MREG_W-1:0] mrf_idx;
    logic [1:0]        mrf_row;
    logic [ROW_W-1:0]  mrf_wdata, mrf_rdata;

    matrix_ls_responder #(
        .MAT_DIM(MAT_DIM), .ROW_W(ROW_W), .ADDR_W(ADDR_W), .MREG_W(MREG_W)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .req      (rif),
        .mem_ren  (mem_ren),
        .mem_wen  (mem_wen),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ready(mem_ready),
        .mrf_wen  (mrf_wen),
        .mrf_ren  (mrf_ren),
        .mrf_idx  (mrf_idx),
        .mrf_row  (mrf_row),
        .mrf_wdata(mrf_wdata),
        .mrf_rdata(mrf_rdata)
    );

    int  checks = 0;
    int  errors = 0;
    int  cyc    = 0;
    int  stall_cycles = 0;
    int  pend = 0;
    bit  mon_en = 1'b0;
    ev_t exp_q[$];

    // Memory contents are a fixed function of the address.
    function automatic logic [ROW_W-1:0] mem_val(input logic [ADDR_W-1:0] a);
        return {a ^ 32'h5A5A_0000, ~a};
    endfunction

    // Matrix RF contents are a fixed function of register and row.
    function automatic logic [ROW_W-1:0] rf_val(input logic [MREG_W-1:0] idx, input logic [1:0] row);
        return {16'hC0DE, 8'(idx), 8'(row), 16'hFACE, 8'(idx), 8'(row)};
    endfunction

    assign mem_rdata = mem_val(mem_addr);

    always @(posedge CLK) begin
        if (mrf_ren) mrf_rdata <= rf_val(mrf_idx, mrf_row);
    end

    always @(posedge CLK) cyc <= cyc + 1;

    // mem_ready: always 1 when stall_cycles is 0, otherwise each access is
    // held off for stall_cycles cycles before completing.
    always @(posedge CLK) begin
        #1;
        if (mem_ren || mem_wen) begin
            if (pend >= stall_cycles) begin
                mem_ready = 1'b1;
                pend      = 0;
            end else begin
                mem_ready = 1'b0;
                pend      = pend + 1;
            end
        end else begin
            mem_ready = (stall_cycles == 0);
            pend      = 0;
        end
    end

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic score(input ev_t g);
        ev_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event got kind %0d addr %0h expected none (cycle %0d)",
                     g.kind, g.addr, cyc);
            return;
        end
        e = exp_q.pop_front();
        check("ev_kind", g.kind, e.kind);
        check("ev_addr", g.addr, e.addr);
        check("ev_data", g.data, e.data);
        check("ev_idx",  g.idx,  e.idx);
        check("ev_row",  g.row,  e.row);
        check("ev_err",  g.err,  e.err);
        if (e.cyc >= 0) check("ev_cycle", g.cyc, e.cyc);
    endtask

    // Monitor: sampled on the falling edge, away from the active edge.
    bit                hold_pending = 1'b0;
    logic [ADDR_W-1:0] hold_addr;
    logic [ROW_W-1:0]  hold_data;

    always @(negedge CLK) begin
        ev_t g;
        if (mon_en) begin
            check("mem_strobe_excl", mem_ren & mem_wen, 0);
            check("mrf_strobe_excl", mrf_ren & mrf_wen, 0);
            check("mrf_wen_only_on_beat", mrf_wen & ~(mem_ren & mem_ready), 0);
            check("err_only_with_mhit", rif.err & ~rif.mhit, 0);
            if (hold_pending) begin
                check("wr_hold_en",   mem_wen,   1);
                check("wr_hold_addr", mem_addr,  hold_addr);
                check("wr_hold_data", mem_wdata, hold_data);
            end
            hold_pending = mem_wen && !mem_ready;
            hold_addr    = mem_addr;
            hold_data    = mem_wdata;

            g = '{kind: EV_LD, addr: '0, data: '0, idx: '0, row: '0, err: 1'b0, cyc: cyc};
            if (mem_ren && mem_ready) begin
                check("ld_mrf_wen", mrf_wen, 1);
                g.kind = EV_LD;  g.addr = mem_addr;  g.data = mrf_wdata;
                g.idx  = mrf_idx; g.row = mrf_row;
                score(g);
            end
            if (mrf_ren) begin
                g = '{kind: EV_SRD, addr: '0, data: '0, idx: mrf_idx, row: mrf_row, err: 1'b0, cyc: cyc};
                score(g);
            end
            if (mem_wen && mem_ready) begin
                g = '{kind: EV_SWR, addr: mem_addr, data: mem_wdata, idx: '0, row: '0, err: 1'b0, cyc: cyc};
                score(g);
            end
            if (rif.mhit) begin
                g = '{kind: EV_HIT, addr: '0, data: '0, idx: '0, row: '0, err: rif.err, cyc: cyc};
                score(g);
            end
        end
    end

    task automatic check_idle(input string tag);
        check($sformatf("%s_strobes", tag),
              {rif.req_ready, mem_ren, mem_wen, mrf_ren, mrf_wen, rif.mhit, rif.err}, 7'b100_0000);
        check($sformatf("%s_mem_addr", tag), mem_addr, 0);
    endtask

    // Issue one request for a single accept edge and push what it must produce.
    // rows/hit allow a truncated expectation for the mid-transfer reset case.
    task automatic do_req(input logic [1:0] ls, input logic [MREG_W-1:0] rd,
                          input logic [ADDR_W-1:0] base, input logic [ADDR_W-1:0] stride,
                          input bit timed, input int rows, input bit hit, output int b);
        bit err_path = 1'b0;
        logic [ADDR_W-1:0] a;
        @(negedge CLK);
        check("accept_ready", rif.req_ready, 1);
        b = cyc;
`ifdef MLS_ALIGN_CHECK_EN
        err_path = |((base | stride) & 32'h7);
`endif
        if (err_path) begin
            exp_q.push_back('{kind: EV_HIT, addr: '0, data: '0, idx: '0, row: '0, err: 1'b1, cyc: b + 1});
        end else begin
            for (int i = 0; i < rows; i++) begin
                a = base + stride * ADDR_W'(i);
                if (ls == 2'b01) begin
                    exp_q.push_back('{kind: EV_LD, addr: a, data: mem_val(a), idx: rd, row: 2'(i),
                                      err: 1'b0, cyc: timed ? b + 1 + i : -1});
                end else begin
                    exp_q.push_back('{kind: EV_SRD, addr: '0, data: '0, idx: rd, row: 2'(i),
                                      err: 1'b0, cyc: timed ? b + 1 + 2 * i : -1});
                    exp_q.push_back('{kind: EV_SWR, addr: a, data: rf_val(rd, 2'(i)), idx: '0, row: '0,
                                      err: 1'b0, cyc: timed ? b + 2 + 2 * i : -1});
                end
            end
            if (hit) begin
                exp_q.push_back('{kind: EV_HIT, addr: '0, data: '0, idx: '0, row: '0, err: 1'b0,
                                  cyc: !timed ? -1 : (ls == 2'b01 ? b + 1 + MAT_DIM : b + 1 + 2 * MAT_DIM)});
            end
        end
        rif.req_ls      = ls;
        rif.req_rd      = rd;
        rif.req_address = base;
        rif.req_stride  = stride;
        @(negedge CLK);
        rif.req_ls = 2'b00;
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge CLK);
            n++;
        end
        check($sformatf("%s_drained", tag), exp_q.size(), 0);
        exp_q.delete();
        repeat (3) @(negedge CLK);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got no finish expected finish by 200000");
        $fatal(1);
    end

    initial begin
        int b;
        rif.req_ls      = 2'b00;
        rif.req_rd      = '0;
        rif.req_stride  = '0;
        rif.req_address = '0;
        RST             = 1'b1;
        repeat (3) @(negedge CLK);
        check_idle("reset");
        RST    = 1'b0;
        mon_en = 1'b1;

        // Basic load, ready tied high: beats cycles 1-4, mhit cycle 5.
        do_req(2'b01, 4'd5, 32'h0000_0100, 32'h40, 1'b1, 4, 1'b1, b);
        wait_drain("load_basic");

        // Store with two stall cycles per beat.
        stall_cycles = 2;
        do_req(2'b10, 4'd3, 32'h0000_2000, 32'h8, 1'b0, 4, 1'b1, b);
        wait_drain("store_stall");
        stall_cycles = 0;

        // Address wrap past the top of the address space.
        do_req(2'b01, 4'd1, 32'hFFFF_FFF0, 32'h10, 1'b1, 4, 1'b1, b);
        wait_drain("load_wrap");

        // Unstalled store with stride 0: mhit on cycle 9, same address each row.
        do_req(2'b10, 4'd7, 32'h0000_0040, 32'h0, 1'b1, 4, 1'b1, b);
        wait_drain("store_stride0");

        // Reset right after row 1 of a load.
        do_req(2'b01, 4'd2, 32'h0000_0300, 32'h8, 1'b1, 2, 1'b0, b);
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        check_idle("mid_reset");
        RST = 1'b0;
        repeat (8) @(negedge CLK);
        wait_drain("mid_reset");
        do_req(2'b01, 4'd9, 32'h0000_0800, 32'h18, 1'b1, 4, 1'b1, b);
        wait_drain("after_reset_load");

        // Illegal req_ls = 11 is ignored.
        @(negedge CLK);
        rif.req_ls      = 2'b11;
        rif.req_address = 32'h0000_0500;
        repeat (3) begin
            @(negedge CLK);
            check("illegal_ready", rif.req_ready, 1);
            check("illegal_no_strobe", {mem_ren, mem_wen, mrf_ren, mrf_wen}, 0);
        end
        rif.req_ls = 2'b00;
        repeat (2) @(negedge CLK);

        // A second request while busy is ignored.
        do_req(2'b01, 4'd4, 32'h0000_0600, 32'h8, 1'b1, 4, 1'b1, b);
        rif.req_ls      = 2'b01;
        rif.req_rd      = 4'hF;
        rif.req_address = 32'h0000_0999;
        repeat (2) begin
            @(negedge CLK);
            check("busy_ready", rif.req_ready, 0);
        end
        rif.req_ls = 2'b00;
        wait_drain("busy_ignore");

        // Misaligned base: err path with the check enabled, plain load otherwise.
        do_req(2'b01, 4'd6, 32'h0000_0104, 32'h8, 1'b1, 4, 1'b1, b);
        wait_drain("misaligned");

        check("final_queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
